// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory-stage access controller. Turns a MEM-stage load/store into a
// req/ack data-memory bus cycle with byte enables and lane-replicated store
// data. It stalls the pipeline until the cycle completes or times out, then
// hands the raw read word, address low bits and extension opcode to the
// load data extender.
//
// Optional feature macro: MISALIGN_EXC_EN
//   defined   : misaligned requests skip the bus and pulse exc_adel/exc_ades
//   undefined : misaligned addresses are force-aligned, exc_* tied to 0
//
// Parameters
//   TIMEOUT_CYCLES : bus-wait limit in cycles (1..255), 0 disables timeout
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   req_valid/we/size    : MEM-stage request qualifiers
//   req_addr/wdata/dm_op : request address, right-aligned store data, ext code
//   stall                : pipeline freeze (combinational)
//   bus_req/we/addr/be/wdata : bus request side, stable while bus_req=1
//   bus_ack/rdata        : bus completion and read word
//   mem_data/mem_addr/dm_op : captured results for the extender
//   rd_valid             : load result valid pulse (DONE only)
//   exc_adel/exc_ades    : misaligned load/store pulses (DONE only)
//   bus_err              : timeout pulse (DONE only)
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dm_op,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] mem_data,
    output logic [1:0]  mem_addr,
    output logic [2:0]  dm_op,
    output logic        rd_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  lo_q;
    logic [2:0]  op_q;

    logic        size_word;
    logic        size_half;
    logic [1:0]  lo_eff;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        timeout_hit;

    // Request decode. lo_eff is the address low bits with misaligned half/word
    // accesses forced onto their natural boundary; for aligned requests it is
    // simply req_addr[1:0], so the same value serves both build flavours.
    always_comb begin
        size_word  = req_size[1];
        size_half  = (req_size == 2'd1);
        lo_eff     = req_addr[1:0];
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
        if (size_word) begin
            lo_eff     = 2'b00;
            be_next    = 4'b1111;
            wdata_next = req_wdata;
        end else if (size_half) begin
            lo_eff     = {req_addr[1], 1'b0};
            be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{req_wdata[15:0]}};
        end
    end

    // Expiry is checked on the last allowed wait cycle so that bus_req stays
    // up for exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

    // Held high through the whole access and released in DONE, the cycle in
    // which the pipeline consumes the result.
    assign stall = req_valid & (state != DONE);

`ifdef MISALIGN_EXC_EN
    logic misaligned;
    assign misaligned = (size_half & req_addr[0]) | (size_word & (|req_addr[1:0]));
`else
    assign exc_adel = 1'b0;
    assign exc_ades = 1'b0;
`endif

    // Main controller. Pulse outputs default low every cycle and are only
    // raised on the transition into DONE, so they last exactly that cycle.
    // Address low bits and dm_op are latched at acceptance because the MEM
    // stage may drop req_valid (and change its fields) while the bus cycle
    // is still running.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            lo_q      <= 2'b00;
            op_q      <= 3'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            mem_data  <= 32'd0;
            mem_addr  <= 2'b00;
            dm_op     <= 3'd0;
            rd_valid  <= 1'b0;
            bus_err   <= 1'b0;
`ifdef MISALIGN_EXC_EN
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            bus_err  <= 1'b0;
`ifdef MISALIGN_EXC_EN
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
`ifdef MISALIGN_EXC_EN
                        if (misaligned) begin
                            state    <= DONE;
                            exc_adel <= ~req_we;
                            exc_ades <= req_we;
                            mem_addr <= req_addr[1:0];
                            dm_op    <= req_dm_op;
                        end else begin
`else
                        begin
`endif
                            state     <= BUSY;
                            bus_req   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= wdata_next;
                            wait_cnt  <= 8'd0;
                            lo_q      <= lo_eff;
                            op_q      <= req_dm_op;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        state    <= DONE;
                        bus_req  <= 1'b0;
                        mem_addr <= lo_q;
                        dm_op    <= op_q;
                        if (!bus_we) begin
                            mem_data <= bus_rdata;
                            rd_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state    <= DONE;
                        bus_req  <= 1'b0;
                        mem_data <= 32'd0;
                        mem_addr <= lo_q;
                        dm_op    <= op_q;
                        bus_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed self-checking bench for mem_access_ctrl, built with
// TIMEOUT_CYCLES=4. Inputs are driven and outputs sampled around the falling
// clock edge. Expectations for misaligned accesses follow MISALIGN_EXC_EN.
module tb_mem_access_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dm_op;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] mem_data;
    logic [1:0]  mem_addr;
    logic [2:0]  dm_op;
    logic        rd_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_dm_op (req_dm_op),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .dm_op     (dm_op),
        .rd_valid  (rd_valid),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set up a request for the current cycle.
    task automatic set_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] op);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        req_dm_op = op;
    endtask

    // Plays the bus slave: acks in the ack_at-th bus_req cycle (0 = never).
    // Called in cycle 0 of a request; returns in the first non-stalled cycle.
    task automatic run_access(input int ack_at, output int stalls, output int breqs,
                              output bit hung);
        stalls = 0;
        breqs  = 0;
        hung   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus_req) begin
                breqs++;
                bus_ack = (breqs == ack_at);
            end else begin
                bus_ack = 1'b0;
            end
            #1;
            if (!stall) begin
                hung = 1'b0;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_1000;
        req_wdata = 32'd0;
        req_dm_op = 3'd0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 1", stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req: got %b expected 0", bus_req); end
        checks++; if ({bus_addr, bus_be, bus_wdata, bus_we} !== 69'd0) begin errors++; $display("[TB] FAIL reset_bus_fields: got %h expected 0", {bus_addr, bus_be, bus_wdata, bus_we}); end
        checks++; if ({mem_data, mem_addr, dm_op} !== 37'd0) begin errors++; $display("[TB] FAIL reset_mem_fields: got %h expected 0", {mem_data, mem_addr, dm_op}); end
        checks++; if ({rd_valid, exc_adel, exc_ades, bus_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {rd_valid, exc_adel, exc_ades, bus_err}); end
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_word;
        int s, b; bit h;
        @(negedge clk);
        bus_rdata = 32'hDEAD_BEEF;
        set_req(1'b0, 2'd2, 32'h0000_1000, 32'd0, 3'd0);
        run_access(1, s, b, h);
        checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL lw_done: got hung=%b expected 0", h); end
        checks++; if (s !== 2) begin errors++; $display("[TB] FAIL lw_stalls: got %0d expected 2", s); end
        checks++; if (bus_be !== 4'b1111) begin errors++; $display("[TB] FAIL lw_be: got %b expected 1111", bus_be); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_rd_valid: got %b expected 1", rd_valid); end
        checks++; if (mem_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lw_mem_data: got %h expected deadbeef", mem_data); end
        checks++; if (mem_addr !== 2'd0) begin errors++; $display("[TB] FAIL lw_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_bus_req_done: got %b expected 0", bus_req); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw_rd_valid_pulse: got %b expected 0", rd_valid); end
    endtask

    task automatic test_store_byte;
        int s, b; bit h;
        @(negedge clk);
        set_req(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 3'd0);
        run_access(3, s, b, h);
        checks++; if (h !== 1'b0 || s !== 4) begin errors++; $display("[TB] FAIL sb_stalls: got %0d (hung=%b) expected 4", s, h); end
        checks++; if (bus_be !== 4'b1000) begin errors++; $display("[TB] FAIL sb_be: got %b expected 1000", bus_be); end
        checks++; if (bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL sb_wdata: got %h expected a5a5a5a5", bus_wdata); end
        checks++; if (bus_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL sb_addr: got %h expected 00001000", bus_addr); end
        checks++; if (bus_we !== 1'b1) begin errors++; $display("[TB] FAIL sb_we: got %b expected 1", bus_we); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL sb_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (mem_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sb_mem_data_kept: got %h expected deadbeef", mem_data); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_load_half;
        int s, b; bit h;
        @(negedge clk);
        bus_rdata = 32'h8001_1234;
        set_req(1'b0, 2'd1, 32'h0000_2002, 32'd0, 3'd4);
        run_access(2, s, b, h);
        checks++; if (h !== 1'b0 || s !== 3) begin errors++; $display("[TB] FAIL lh_stalls: got %0d (hung=%b) expected 3", s, h); end
        checks++; if (bus_be !== 4'b1100) begin errors++; $display("[TB] FAIL lh_be: got %b expected 1100", bus_be); end
        checks++; if (mem_addr !== 2'd2) begin errors++; $display("[TB] FAIL lh_mem_addr: got %0d expected 2", mem_addr); end
        checks++; if (dm_op !== 3'd4) begin errors++; $display("[TB] FAIL lh_dm_op: got %0d expected 4", dm_op); end
        checks++; if (mem_data !== 32'h8001_1234 || rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL lh_data: got %h/%b expected 80011234/1", mem_data, rd_valid); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_timeout;
        int s, b; bit h;
        @(negedge clk);
        set_req(1'b0, 2'd2, 32'h0000_4010, 32'd0, 3'd1);
        run_access(0, s, b, h);
        checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL to_done: got hung=%b expected 0", h); end
        checks++; if (b !== 4) begin errors++; $display("[TB] FAIL to_bus_req_cycles: got %0d expected 4", b); end
        checks++; if (s !== 5) begin errors++; $display("[TB] FAIL to_stalls: got %0d expected 5", s); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL to_bus_err: got %b expected 1", bus_err); end
        checks++; if (mem_data !== 32'd0) begin errors++; $display("[TB] FAIL to_mem_data: got %h expected 0", mem_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_rd_valid: got %b expected 0", rd_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (bus_err !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL to_idle: got err=%b req=%b expected 0/0", bus_err, bus_req); end
    endtask

    task automatic test_misaligned;
        int s, b; bit h;
        @(negedge clk);
        bus_rdata = 32'h1122_3344;
        set_req(1'b0, 2'd2, 32'h0000_3001, 32'd0, 3'd0);
        run_access(1, s, b, h);
        checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_done: got hung=%b expected 0", h); end
`ifdef MISALIGN_EXC_EN
        checks++; if (b !== 0) begin errors++; $display("[TB] FAIL mis_lw_no_bus: got %0d bus cycles expected 0", b); end
        checks++; if (exc_adel !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_exc: got adel=%b rdv=%b expected 1/0", exc_adel, rd_valid); end
`else
        checks++; if (bus_addr !== 32'h0000_3000) begin errors++; $display("[TB] FAIL mis_lw_addr: got %h expected 00003000", bus_addr); end
        checks++; if (mem_addr !== 2'd0) begin errors++; $display("[TB] FAIL mis_lw_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (rd_valid !== 1'b1 || mem_data !== 32'h1122_3344 || exc_adel !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_complete: got rdv=%b data=%h adel=%b expected 1/11223344/0", rd_valid, mem_data, exc_adel); end
`endif
        @(negedge clk);
        set_req(1'b1, 2'd1, 32'h0000_2005, 32'h0000_BEEF, 3'd0);
        run_access(1, s, b, h);
`ifdef MISALIGN_EXC_EN
        checks++; if (exc_ades !== 1'b1 || b !== 0) begin errors++; $display("[TB] FAIL mis_sh_exc: got ades=%b bus=%0d expected 1/0", exc_ades, b); end
`else
        checks++; if (bus_be !== 4'b0011 || bus_wdata !== 32'hBEEF_BEEF || exc_ades !== 1'b0) begin errors++; $display("[TB] FAIL mis_sh_aligned: got be=%b wdata=%h ades=%b expected 0011/beefbeef/0", bus_be, bus_wdata, exc_ades); end
`endif
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        int s, b; bit h;
        @(negedge clk);
        bus_rdata = 32'hCAFE_0001;
        set_req(1'b0, 2'd2, 32'h0000_4000, 32'd0, 3'd0);
        run_access(1, s, b, h);
        checks++; if (rd_valid !== 1'b1 || mem_data !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL b2b_first: got rdv=%b data=%h expected 1/cafe0001", rd_valid, mem_data); end
        @(negedge clk);
        set_req(1'b1, 2'd2, 32'h0000_4004, 32'h1234_5678, 3'd0);
        run_access(2, s, b, h);
        checks++; if (h !== 1'b0 || s !== 3) begin errors++; $display("[TB] FAIL b2b_stalls: got %0d (hung=%b) expected 3", s, h); end
        checks++; if (bus_addr !== 32'h0000_4004 || bus_wdata !== 32'h1234_5678 || bus_be !== 4'b1111) begin errors++; $display("[TB] FAIL b2b_bus: got %h/%h/%b expected 00004004/12345678/1111", bus_addr, bus_wdata, bus_be); end
        @(negedge clk);
        set_req(1'b1, 2'd0, 32'h0000_5001, 32'h0000_003C, 3'd0);
        run_access(1, s, b, h);
        checks++; if (bus_be !== 4'b0010 || bus_wdata !== 32'h3C3C_3C3C) begin errors++; $display("[TB] FAIL b2b_sb_lane1: got %b/%h expected 0010/3c3c3c3c", bus_be, bus_wdata); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_ack_outside_busy;
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_ignored: got rdv=%b req=%b expected 0/0", rd_valid, bus_req); end
    endtask

    task automatic test_drop_valid;
        @(negedge clk);
        bus_rdata = 32'h0BAD_F00D;
        set_req(1'b0, 2'd2, 32'h0000_6000, 32'd0, 3'd2);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_dm_op = 3'd7;
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1 || mem_data !== 32'h0BAD_F00D || dm_op !== 3'd2) begin errors++; $display("[TB] FAIL drop_valid_completes: got rdv=%b data=%h op=%0d expected 1/0badf00d/2", rd_valid, mem_data, dm_op); end
    endtask

    task automatic test_reset_mid_busy;
        int s, b; bit h;
        @(negedge clk);
        set_req(1'b0, 2'd2, 32'h0000_7000, 32'd0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy_pre: got %b expected 1", bus_req); end
        resetn = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || bus_addr !== 32'd0) begin errors++; $display("[TB] FAIL rst_busy_drop: got req=%b addr=%h expected 0/0", bus_req, bus_addr); end
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy_stall: got %b expected 1", stall); end
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus_rdata = 32'h5555_AAAA;
        set_req(1'b0, 2'd2, 32'h0000_7004, 32'd0, 3'd3);
        run_access(1, s, b, h);
        checks++; if (h !== 1'b0 || s !== 2 || rd_valid !== 1'b1 || mem_data !== 32'h5555_AAAA) begin errors++; $display("[TB] FAIL rst_recover: got stalls=%0d rdv=%b data=%h expected 2/1/5555aaaa", s, rd_valid, mem_data); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] mem_access_ctrl directed tests");
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_half();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_ack_outside_busy();
        test_drop_valid();
        test_reset_mid_busy();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
